// File: rtl/filter_pkg.sv
// Shared types and constants for the image-filter Avalon-MM master.
package filter_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    localparam int unsigned AVM_AW = 4;
    localparam int unsigned AVM_DW = 32;

    localparam logic [AVM_AW-1:0] PIXEL_0_ADDR = 4'h0;
    localparam logic [AVM_AW-1:0] PIXEL_1_ADDR = 4'h1;
    localparam logic [AVM_AW-1:0] PIXEL_2_ADDR = 4'h2;
    localparam logic [AVM_AW-1:0] PIXEL_3_ADDR = 4'h3;
    localparam logic [AVM_AW-1:0] PIXEL_4_ADDR = 4'h4;
    localparam logic [AVM_AW-1:0] PIXEL_5_ADDR = 4'h5;
    localparam logic [AVM_AW-1:0] PIXEL_6_ADDR = 4'h6;
    localparam logic [AVM_AW-1:0] PIXEL_7_ADDR = 4'h7;
    localparam logic [AVM_AW-1:0] PIXEL_8_ADDR = 4'h8;

    // Colour channel positions inside one 24-bit pixel.
    localparam int unsigned R_LSB = 0;
    localparam int unsigned R_MSB = 7;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned G_MSB = 15;
    localparam int unsigned B_LSB = 16;
    localparam int unsigned B_MSB = 23;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

endpackage

// File: rtl/window_buffer.sv
// Storage for one filter window: synchronous write port, asynchronous read port.
module window_buffer #(
    parameter int unsigned NUM_PIXELS = 9,
    parameter int unsigned PIX_W      = 24,
    parameter int unsigned IDX_W      = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [NUM_PIXELS];

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_idx) < NUM_PIXELS)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Out-of-range indices read as zero rather than an undefined entry.
    assign rd_data = (32'(rd_idx) < NUM_PIXELS) ? mem[rd_idx] : '0;

endmodule

// File: rtl/filter_window_master.sv
// Collects a 3x3 RGB window, writes it to the filter slave, reads back the
// filtered byte and hands it downstream; aborts stalled transfers with a sticky error.
module filter_window_master
    import filter_pkg::*;
#(
    parameter int unsigned BIT_PER_PIXEL  = 8,
    parameter int unsigned NUM_PIXELS     = 9,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3*BIT_PER_PIXEL-1:0] in_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BIT_PER_PIXEL-1:0]   out_data,
    output logic [AVM_AW-1:0]          avm_address,
    output logic                       avm_write,
    output logic [AVM_DW-1:0]          avm_writedata,
    output logic                       avm_read,
    input  logic [AVM_DW-1:0]          avm_readdata,
    input  logic                       avm_waitrequest,
    output logic                       busy,
    output logic                       err,
    output logic [15:0]                win_count
);

    localparam int unsigned PIX_W  = 3 * BIT_PER_PIXEL;
    localparam int unsigned IDX_W  = AVM_AW;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PIXELS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    pix_idx_q, pix_idx_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic                in_ready_d;
    logic                out_valid_d;
    logic [BIT_PER_PIXEL-1:0] out_data_d;
    logic [AVM_AW-1:0]   avm_address_d;
    logic                avm_write_d;
    logic [AVM_DW-1:0]   avm_writedata_d;
    logic                avm_read_d;
    logic                busy_d;
    logic                err_d;
    logic [15:0]         win_count_d;

    logic                in_accept_c;
    logic                wr_accept_c;
    logic                rd_accept_c;
    logic                stall_c;
    logic                timeout_c;
    logic                wr_last_c;
    logic [IDX_W-1:0]    buf_rd_idx_c;
    logic [PIX_W-1:0]    buf_rd_data;
    logic                unused_readdata;

    assign unused_readdata = ^avm_readdata[AVM_DW-1:BIT_PER_PIXEL];

    // Transfer qualifiers shared by the FSM and the buffer read index.
    assign in_accept_c = (state_q == ST_FILL)  && in_ready  && in_valid;
    assign wr_accept_c = (state_q == ST_WRITE) && avm_write && !avm_waitrequest;
    assign rd_accept_c = (state_q == ST_READ)  && avm_read  && !avm_waitrequest;
    assign stall_c     = (avm_write || avm_read) && avm_waitrequest;
    assign timeout_c   = stall_c && (wait_cnt_q == WAIT_LAST);
    assign wr_last_c   = (wr_idx_q == LAST_IDX);

    // Look one pixel ahead so the registered write data lines up with its address.
    assign buf_rd_idx_c = wr_accept_c ? (wr_last_c ? '0 : wr_idx_q + IDX_W'(1)) : wr_idx_q;

    window_buffer #(
        .NUM_PIXELS (NUM_PIXELS),
        .PIX_W      (PIX_W),
        .IDX_W      (IDX_W)
    ) u_window_buffer (
        .clk     (clk),
        .wr_en   (in_accept_c),
        .wr_idx  (pix_idx_q),
        .wr_data (in_pixel),
        .rd_idx  (buf_rd_idx_c),
        .rd_data (buf_rd_data)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_FILL;
            pix_idx_q     <= '0;
            wr_idx_q      <= '0;
            wait_cnt_q    <= '0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            win_count     <= '0;
        end else begin
            state_q       <= state_d;
            pix_idx_q     <= pix_idx_d;
            wr_idx_q      <= wr_idx_d;
            wait_cnt_q    <= wait_cnt_d;
            in_ready      <= in_ready_d;
            out_valid     <= out_valid_d;
            out_data      <= out_data_d;
            avm_address   <= avm_address_d;
            avm_write     <= avm_write_d;
            avm_writedata <= avm_writedata_d;
            avm_read      <= avm_read_d;
            busy          <= busy_d;
            err           <= err_d;
            win_count     <= win_count_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        pix_idx_d       = pix_idx_q;
        wr_idx_d        = wr_idx_q;
        wait_cnt_d      = stall_c ? wait_cnt_q + WAIT_W'(1) : '0;
        in_ready_d      = 1'b0;
        out_valid_d     = out_valid;
        out_data_d      = out_data;
        avm_address_d   = avm_address;
        avm_write_d     = avm_write;
        avm_writedata_d = avm_writedata;
        avm_read_d      = avm_read;
        err_d           = err;
        win_count_d     = win_count;

        case (state_q)
            ST_FILL: begin
                in_ready_d = 1'b1;
                if (in_accept_c) begin
                    if (pix_idx_q == LAST_IDX) begin
                        pix_idx_d       = '0;
                        in_ready_d      = 1'b0;
                        avm_write_d     = 1'b1;
                        avm_address_d   = PIXEL_0_ADDR;
                        avm_writedata_d = AVM_DW'(buf_rd_data);
                        state_d         = ST_WRITE;
                    end else begin
                        pix_idx_d = pix_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (wr_accept_c) begin
                    if (wr_last_c) begin
                        wr_idx_d      = '0;
                        avm_write_d   = 1'b0;
                        avm_read_d    = 1'b1;
                        avm_address_d = PIXEL_0_ADDR;
                        state_d       = ST_READ;
                    end else begin
                        wr_idx_d        = wr_idx_q + IDX_W'(1);
                        avm_address_d   = AVM_AW'(wr_idx_q + IDX_W'(1));
                        avm_writedata_d = AVM_DW'(buf_rd_data);
                    end
                end
            end
            ST_READ: begin
                if (rd_accept_c) begin
                    avm_read_d  = 1'b0;
                    out_data_d  = avm_readdata[BIT_PER_PIXEL-1:0];
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    win_count_d = win_count + 16'd1;
                    in_ready_d  = 1'b1;
                    state_d     = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        // A stalled slave abandons the partial window and returns to FILL.
        if (timeout_c) begin
            state_d     = ST_FILL;
            avm_write_d = 1'b0;
            avm_read_d  = 1'b0;
            err_d       = 1'b1;
            wr_idx_d    = '0;
            pix_idx_d   = '0;
            wait_cnt_d  = '0;
            in_ready_d  = 1'b1;
        end

        busy_d = (state_d != ST_FILL);
    end

endmodule

// File: tb/tb_filter_window_master.sv
// Self-checking bench for filter_window_master with a behavioural Avalon filter slave.
module tb_filter_window_master;

    typedef logic [8:0][23:0] win_t;
    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_pixel;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [3:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        err;
    logic [15:0] win_count;

    int checks = 0;
    int errors = 0;

    filter_window_master dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pixel        (in_pixel),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .err             (err),
        .win_count       (win_count)
    );

    always #5 clk = ~clk;

    // Slave model state and transfer log
    int   wait_mode  = 0;   // 0 none, 1 random, 2 stall reads, 3 stall write addr 4
    int   stall_left = 0;
    bit   force_en   = 1'b0;
    logic [7:0] force_val = 8'h00;
    win_t slave_mem;
    wr_t  wr_q [$];
    int   wr_cyc [$];
    int   cyc = 0;
    int   both_hi = 0;
    int   a4_cycles = 0;
    int   a4_bad = 0;
    logic [31:0] a4_exp = '0;

    function automatic logic [7:0] filt(input win_t w);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 9; i++) s = s + w[i][15:8];
        return s ^ w[4][7:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Slave response, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        case (wait_mode)
            1: avm_waitrequest = ($urandom_range(0, 3) == 0);
            2: avm_waitrequest = avm_read;
            3: begin
                if (avm_write && avm_address == 4'd4 && stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end
            default: avm_waitrequest = 1'b0;
        endcase
        avm_readdata = {24'($urandom), force_en ? force_val : filt(slave_mem)};
    end

    // Bus monitor between edges
    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_write && avm_read) both_hi++;
            if (avm_write && avm_address == 4'd4) begin
                a4_cycles++;
                if (avm_writedata !== a4_exp) a4_bad++;
            end
            if (avm_write && !avm_waitrequest) begin
                wr_q.push_back({avm_address, avm_writedata});
                wr_cyc.push_back(cyc);
                if (avm_address < 4'd9) slave_mem[avm_address] = avm_writedata[23:0];
            end
        end
    end

    function automatic win_t rand_win();
        win_t w;
        for (int i = 0; i < 9; i++) w[i] = 24'($urandom);
        return w;
    endfunction

    task automatic send_pixel(input logic [23:0] p, input int gap_max);
        int n;
        bit got;
        n = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_pixel = p;
        got = 1'b0;
        for (int t = 0; t < 3000 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL pixel_accept: in_ready=%0b after 3000 cycles, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_window(input win_t w, input int gap_max);
        for (int i = 0; i < 9; i++) send_pixel(w[i], gap_max);
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL out_valid_wait: out_valid=%0b after 2000 cycles, required 1", out_valid);
        end
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_writes(input string name, input win_t w[$]);
        int bad;
        bad = 0;
        if (wr_q.size() != 9 * w.size()) bad++;
        else
            for (int k = 0; k < wr_q.size(); k++)
                if (wr_q[k] !== {4'(k % 9), {8'h00, w[k / 9][k % 9]}}) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d writes with %0d wrong, required %0d exact", name,
                     wr_q.size(), bad, 9 * w.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
        avm_waitrequest = 1'b0; avm_readdata = '0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h exp 00", out_data); end
        checks++; if ({avm_write, avm_read} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b exp 00", {avm_write, avm_read}); end
        checks++; if (avm_address !== 4'h0) begin errors++; $display("FAIL rst_address: got %h exp 0", avm_address); end
        checks++; if (avm_writedata !== 32'h0) begin errors++; $display("FAIL rst_writedata: got %h exp 0", avm_writedata); end
        checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL rst_busy_err: got %b exp 00", {busy, err}); end
        checks++; if (win_count !== 16'h0) begin errors++; $display("FAIL rst_win_count: got %0d exp 0", win_count); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %b exp 0", in_ready); end
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_clk_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_basic();
        win_t w;
        win_t wl [$];
        bit ok;
        for (int i = 0; i < 9; i++) w[i] = 24'(i + 1);
        wl.push_back(w);
        wait_mode = 0; force_en = 1'b1; force_val = 8'h5A;
        wr_q.delete(); wr_cyc.delete();
        send_window(w, 0);
        wait_out(ok);
        if (ok) begin
            check_writes("basic_writes", wl);
            checks++;
            if (wr_cyc.size() != 9 || wr_cyc[8] - wr_cyc[0] != 8) begin
                errors++;
                $display("FAIL basic_consecutive: %0d writes spanning %0d cycles, required 9 over 8",
                         wr_cyc.size(), wr_cyc.size() == 9 ? wr_cyc[8] - wr_cyc[0] : -1);
            end
            checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL basic_out_data: got %h exp 5a", out_data); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_out: got %b exp 1", busy); end
            accept_out();
            checks++; if (win_count !== 16'd1) begin errors++; $display("FAIL basic_win_count: got %0d exp 1", win_count); end
            checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL basic_after_out: valid/ready got %b exp 01", {out_valid, in_ready}); end
        end
        force_en = 1'b0;
    endtask

    task automatic test_write_stall();
        win_t w;
        win_t wl [$];
        bit ok;
        logic [15:0] wc0;
        w = rand_win();
        wl.push_back(w);
        wc0 = win_count;
        wr_q.delete(); wr_cyc.delete();
        a4_exp = {8'h00, w[4]}; a4_cycles = 0; a4_bad = 0;
        stall_left = 3; wait_mode = 3;
        send_window(w, 2);
        wait_out(ok);
        if (ok) begin
            check_writes("stall_writes", wl);
            checks++;
            if (a4_cycles != 4 || a4_bad != 0) begin
                errors++;
                $display("FAIL stall_addr4: %0d cycles (%0d bad data), required 4 (0 bad)", a4_cycles, a4_bad);
            end
            checks++; if (out_data !== filt(w)) begin errors++; $display("FAIL stall_out_data: got %h exp %h", out_data, filt(w)); end
            accept_out();
            checks++; if (win_count !== wc0 + 16'd1) begin errors++; $display("FAIL stall_win_count: got %0d exp %0d", win_count, wc0 + 16'd1); end
        end
        wait_mode = 0;
    endtask

    task automatic test_out_hold();
        win_t w;
        bit ok;
        int bad;
        logic [15:0] wc0;
        w = rand_win();
        wc0 = win_count;
        send_window(w, 1);
        wait_out(ok);
        if (ok) begin
            bad = 0;
            for (int c = 0; c < 10; c++) begin
                if (out_valid !== 1'b1 || out_data !== filt(w) || in_ready !== 1'b0) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL out_hold: %0d of 10 cycles changed, required 0", bad); end
            checks++; if (win_count !== wc0) begin errors++; $display("FAIL out_hold_count: got %0d exp %0d", win_count, wc0); end
            accept_out();
            checks++; if (win_count !== wc0 + 16'd1) begin errors++; $display("FAIL out_hold_accept: got %0d exp %0d", win_count, wc0 + 16'd1); end
        end
    endtask

    task automatic test_timeout();
        win_t w;
        int rd_hi;
        bit done;
        logic [15:0] wc0;
        w = rand_win();
        wc0 = win_count;
        wait_mode = 2;
        send_window(w, 0);
        rd_hi = 0; done = 1'b0;
        for (int t = 0; t < 600 && !done; t++) begin
            @(negedge clk);
            if (avm_read) rd_hi++;
            else if (rd_hi > 0) done = 1'b1;
        end
        checks++; if (rd_hi != 255) begin errors++; $display("FAIL timeout_len: read held %0d cycles, required 255", rd_hi); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b exp 1", err); end
        checks++; if ({busy, in_ready, out_valid, avm_write} !== 4'b0100) begin errors++; $display("FAIL timeout_state: busy/ready/valid/write got %b exp 0100", {busy, in_ready, out_valid, avm_write}); end
        checks++; if (win_count !== wc0) begin errors++; $display("FAIL timeout_count: got %0d exp %0d", win_count, wc0); end
        wait_mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        win_t wl [$];
        logic [7:0] exp_q [$];
        logic [15:0] wc0;
        wc0 = win_count;
        for (int k = 0; k < 3; k++) begin
            wl.push_back(rand_win());
            exp_q.push_back(filt(wl[k]));
        end
        wr_q.delete(); wr_cyc.delete();
        wait_mode = 1;
        fork
            begin
                for (int k = 0; k < 3; k++) send_window(wl[k], 3);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    bit ok;
                    logic [7:0] e;
                    wait_out(ok);
                    if (ok) begin
                        e = exp_q.pop_front();
                        checks++;
                        if (out_data !== e) begin errors++; $display("FAIL b2b_out_data[%0d]: got %h exp %h", k, out_data, e); end
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        accept_out();
                    end
                end
            end
        join
        wait_mode = 0;
        check_writes("b2b_writes", wl);
        checks++; if (win_count !== wc0 + 16'd3) begin errors++; $display("FAIL b2b_win_count: got %0d exp %0d", win_count, wc0 + 16'd3); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL b2b_err_sticky: got %b exp 1", err); end
    endtask

    task automatic test_reset_mid();
        win_t w;
        win_t wl [$];
        bit ok;
        bit hit;
        w = rand_win();
        wr_q.delete(); wr_cyc.delete();
        stall_left = 0;
        send_window(w, 0);
        hit = 1'b0;
        for (int t = 0; t < 100 && !hit; t++) begin
            @(negedge clk);
            if (wr_q.size() >= 6) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL mid_reach_write5: %0d writes, required 6", wr_q.size()); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, avm_write, avm_read, busy, err} !== 6'b0 ||
            out_data !== 8'h00 || avm_address !== 4'h0 || avm_writedata !== 32'h0 || win_count !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: rdy=%b vld=%b wr=%b rd=%b busy=%b err=%b data=%h addr=%h wdata=%h cnt=%0d, required all 0",
                     in_ready, out_valid, avm_write, avm_read, busy, err, out_data, avm_address, avm_writedata, win_count);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        wr_q.delete(); wr_cyc.delete();
        w = rand_win();
        wl.push_back(w);
        send_window(w, 1);
        wait_out(ok);
        if (ok) begin
            check_writes("mid_new_window", wl);
            checks++; if (out_data !== filt(w)) begin errors++; $display("FAIL mid_out_data: got %h exp %h", out_data, filt(w)); end
            accept_out();
            checks++; if (win_count !== 16'd1) begin errors++; $display("FAIL mid_win_count: got %0d exp 1", win_count); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_write_stall();
        test_out_hold();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (both_hi != 0) begin errors++; $display("FAIL strobe_exclusive: %0d cycles with write and read, required 0", both_hi); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
